mem_test_chk: RTL and testbench
===============================

Name: mem_test_chk

Overview:
- Parametrised write/read-back memory test engine that replaces the fixed-pattern pass/fail logic in the image-capture top level.
- Drives one frame-buffer/RAM-interface port: writes NUM_WORDS words, reads them back, and checks in order.
- Supports four pattern modes, bounded outstanding reads, an error count, first-failure capture and a drain timeout.
- Controlled and observed through the in-system sources/probes.

Parameters:
- DATA_W, 32, data word width (≥8).
- ADDR_W, 24, word address width.
- NUM_WORDS, 503, words per pass (1..2^ADDR_W).
- TST_PATT, 32'hFFFFFFFF, constant pattern for mode 0, zero-extended or truncated to DATA_W.
- LFSR_SEED, 32'h0000_0001, LFSR seed for mode 2; must be nonzero.
- LFSR_TAPS, 32'h8020_0003, Galois feedback mask for mode 2, applied to the low DATA_W bits.
- MAX_OUT, 8, maximum reads outstanding.
- ERR_W, 16, error counter width.
- TIMEOUT, 4096, drain timeout in cycles.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; a rising edge sampled in IDLE or DONE launches a pass.
- mode  in  2  0 = const, 1 = address, 2 = LFSR, 3 = walking-one; latched at launch.
- wr_rdy  in  1  port accepts a write this cycle.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- rd_rdy  in  1  port accepts a read request this cycle.
- rd_en  out  1  read request strobe.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  returned read data.
- rd_data_valid  in  1  rd_data is valid this cycle.
- busy  out  1  pass in progress.
- pass  out  1  pass finished with no errors.
- fail  out  1  one or more errors, or a timeout.
- timeout  out  1  drain timeout occurred.
- err_cnt  out  ERR_W  mismatch count; saturates at all ones.
- first_err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset: all outputs 0, state IDLE, all generators cleared.
- States:
  - IDLE: on start rising edge → WRITE. On entry, pass, fail, timeout, err_cnt and first_err_addr are cleared, mode is latched, and the write and check generators are loaded.
  - WRITE → READ after word NUM_WORDS-1 is accepted.
  - READ → DRAIN after read NUM_WORDS-1 is issued.
  - DRAIN → DONE when outstanding == 0 and the check count equals NUM_WORDS, or when the timeout counter reaches TIMEOUT-1; the timeout case sets timeout and fail.
  - DONE: pass = !fail; a new start rising edge → WRITE.
- busy = 1 in WRITE, READ and DRAIN.
- Write handshake:
  - wr_en = (state == WRITE) && wr_rdy, combinational.
  - wr_addr and wr_data are registered and valid throughout WRITE.
  - Address and generator advance on each clock edge where wr_en = 1.
- Read handshake:
  - rd_en = (state == READ) && rd_rdy && (outstanding < MAX_OUT).
  - rd_addr increments from 0 on each issued read.
  - outstanding counts +1 on rd_en and −1 on rd_data_valid; both in the same cycle leaves it unchanged.
- Patterns, for word index i:
  - mode 0: TST_PATT.
  - mode 1: {zero-pad, i}, truncated to DATA_W.
  - mode 2: LFSR state, advanced once per word.
  - mode 3: 1 << (i mod DATA_W).
- Checking:
  - The check generator is independent of the write generator and advances on each rd_data_valid; responses return in order.
  - A mismatch increments err_cnt (saturating) and sets fail. On the first mismatch of a pass, first_err_addr is set to the check index.
  - rd_data_valid with outstanding == 0 counts as one error and sets fail; outstanding stays at 0.
- Stimulus edge cases:
  - start held high does not relaunch; relaunch requires a new rising edge.
  - start edges while busy are ignored.
  - Reset mid-pass aborts immediately to IDLE with outputs cleared; late rd_data_valid after reset release is discarded while in IDLE.
- The timeout counter resets on every rd_data_valid in DRAIN.

Optional Feature:
- Macro: MEM_TEST_CHK_INJ_EN.
- Defined: adds input inj_err (1 bit), sampled at launch. When set, bit 0 of wr_data for word 0 of that pass is inverted, and the following pass must report fail = 1, err_cnt = 1, first_err_addr = 0.
- Undefined: the inj_err port is absent and the behaviour is as specified above.

Decomposition:
- Shared package mem_test_pkg: state encoding (IDLE, WRITE, READ, DRAIN, DONE) and mode constants (MODE_CONST, MODE_ADDR, MODE_LFSR, MODE_WALK).
- One sub-module, mem_test_patgen: parametrised pattern generator with load/advance inputs and a data output. It is instantiated twice, once for write and once for check.

Test Plan:
- Mode 0, NUM_WORDS = 503, zero-latency memory model, wr_rdy and rd_rdy tied high → write takes 503 cycles; DONE gives pass = 1, fail = 0, err_cnt = 0.
- Mode 2, random 30% stalls on wr_rdy and rd_rdy, 3–12 cycle read latency → outstanding never exceeds 8; pass = 1.
- Mode 1, model corrupts words 17 and 200 → fail = 1, err_cnt = 2, first_err_addr = 17.
- Model drops the last read response → after 4096 idle cycles in DRAIN: timeout = 1, fail = 1, pass = 0.
- Extra rd_data_valid injected in READ while outstanding = 0 → err_cnt = 1, fail = 1.
- Reset asserted mid-READ, then start pulse → busy, pass, fail and err_cnt are 0 during reset; the new pass in mode 3 completes with pass = 1.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types for the memory write/read-back test engine.
// Holds the pass state encoding and the pattern mode encoding.
package mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_ADDR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

endpackage

// File: rtl/mem_test_patgen.sv
// Pattern generator: yields the word for index i in the selected mode.
// Output is registered; load restarts at index 0, adv steps one word.
module mem_test_patgen
    import mem_test_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 24,
    parameter logic [31:0] TST_PATT  = 32'hFFFF_FFFF,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              adv,
    input  mode_e             mode,
    output logic [DATA_W-1:0] data
);

    localparam int PW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam logic [DATA_W-1:0] PATT = DATA_W'(TST_PATT);
    localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] walk_q, walk_d;
    logic [DATA_W-1:0] data_q, data_d;

    function automatic logic [DATA_W-1:0] lfsr_step(
        input logic [DATA_W-1:0] s
    );
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(
        input mode_e             m,
        input logic [ADDR_W-1:0] i,
        input logic [DATA_W-1:0] l,
        input logic [DATA_W-1:0] w
    );
        logic [PW-1:0] x;
        x = PW'(i);
        unique case (m)
            MODE_CONST: return PATT;
            MODE_ADDR:  return x[DATA_W-1:0];
            MODE_LFSR:  return l;
            MODE_WALK:  return w;
            default:    return '0;
        endcase
    endfunction

    // next generator state and the pattern word it selects
    always_comb begin
        idx_d  = idx_q;
        lfsr_d = lfsr_q;
        walk_d = walk_q;
        if (load) begin
            idx_d  = '0;
            lfsr_d = SEED;
            walk_d = DATA_W'(1);
        end else if (adv) begin
            idx_d  = idx_q + 1'b1;
            lfsr_d = lfsr_step(lfsr_q);
            walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
        end
        data_d = pattern(mode, idx_d, lfsr_d, walk_d);
    end

    // generator state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            lfsr_q <= '0;
            walk_q <= '0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            lfsr_q <= lfsr_d;
            walk_q <= walk_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/mem_test_chk.sv
// Write/read-back memory test engine with in-order checking.
// Build option MEM_TEST_CHK_INJ_EN adds inj_err (word 0 bit 0 flip).
module mem_test_chk
    import mem_test_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 24,
    parameter int          NUM_WORDS = 503,
    parameter logic [31:0] TST_PATT  = 32'hFFFF_FFFF,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003,
    parameter int          MAX_OUT   = 8,
    parameter int          ERR_W     = 16,
    parameter int          TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
`ifdef MEM_TEST_CHK_INJ_EN
    input  logic              inj_err,
`endif
    input  logic              wr_rdy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_rdy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  NUM_C    = CNT_W'(NUM_WORDS);
    localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_sel;
    logic              start_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [OUT_W-1:0]  out_q;
    logic [CNT_W-1:0]  chk_cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              fail_q;
    logic              tmo_flag_q;
    logic [ERR_W-1:0]  err_q;
    logic [ADDR_W-1:0] ferr_q;
    logic              mis_seen_q;
    logic [DATA_W-1:0] wgen_data;
    logic [DATA_W-1:0] cgen_data;
    logic              launch;
    logic              vld;
    logic              spur;
    logic              chk_ok;
    logic              mism;
    logic              drain_ok;
    logic              tmo_hit;
    logic              inj_bit;

    assign launch = start && !start_q
                    && (state_q == IDLE || state_q == DONE);
    assign busy   = (state_q == WRITE) || (state_q == READ)
                    || (state_q == DRAIN);
    assign wr_en  = (state_q == WRITE) && wr_rdy;
    assign rd_en  = (state_q == READ) && rd_rdy && (out_q < OUT_MAX);

    // responses only matter during a pass; one with nothing
    // outstanding is a protocol error and does not step the checker
    assign vld    = rd_data_valid && busy;
    assign spur   = vld && (out_q == '0);
    assign chk_ok = vld && !spur;
    assign mism   = chk_ok && (rd_data != cgen_data);

    assign drain_ok = (state_q == DRAIN) && (out_q == '0)
                      && (chk_cnt_q == NUM_C);
    assign tmo_hit  = (state_q == DRAIN) && !drain_ok
                      && (tmo_q == TMO_LAST);

    assign mode_sel = launch ? mode_e'(mode) : mode_q;

`ifdef MEM_TEST_CHK_INJ_EN
    logic inj_q;

    // injection request is captured once per pass at launch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inj_q <= 1'b0;
        end else if (launch) begin
            inj_q <= inj_err;
        end
    end

    assign inj_bit = inj_q && (state_q == WRITE) && (wr_addr_q == '0);
`else
    assign inj_bit = 1'b0;
`endif

    mem_test_patgen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .TST_PATT  (TST_PATT),
        .LFSR_SEED (LFSR_SEED),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_wgen (
        .clk   (clk),
        .reset (reset),
        .load  (launch),
        .adv   (wr_en),
        .mode  (mode_sel),
        .data  (wgen_data)
    );

    mem_test_patgen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .TST_PATT  (TST_PATT),
        .LFSR_SEED (LFSR_SEED),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_cgen (
        .clk   (clk),
        .reset (reset),
        .load  (launch),
        .adv   (chk_ok),
        .mode  (mode_sel),
        .data  (cgen_data)
    );

    // pass sequencing: write all, read all, wait for responses
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (launch) state_d = WRITE;
            WRITE: if (wr_en && wr_addr_q == LAST) state_d = READ;
            READ:  if (rd_en && rd_addr_q == LAST) state_d = DRAIN;
            DRAIN: if (drain_ok || tmo_hit) state_d = DONE;
            DONE:  if (launch) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // addresses, outstanding count, checker results and timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q    <= 1'b0;
            mode_q     <= MODE_CONST;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            out_q      <= '0;
            chk_cnt_q  <= '0;
            tmo_q      <= '0;
            fail_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            err_q      <= '0;
            ferr_q     <= '0;
            mis_seen_q <= 1'b0;
        end else begin
            start_q <= start;
            if (launch) begin
                mode_q     <= mode_e'(mode);
                wr_addr_q  <= '0;
                rd_addr_q  <= '0;
                out_q      <= '0;
                chk_cnt_q  <= '0;
                fail_q     <= 1'b0;
                tmo_flag_q <= 1'b0;
                err_q      <= '0;
                ferr_q     <= '0;
                mis_seen_q <= 1'b0;
            end else begin
                if (wr_en) wr_addr_q <= wr_addr_q + 1'b1;
                if (rd_en) rd_addr_q <= rd_addr_q + 1'b1;
                if (rd_en && !chk_ok) out_q <= out_q + 1'b1;
                if (!rd_en && chk_ok) out_q <= out_q - 1'b1;
                if (chk_ok) chk_cnt_q <= chk_cnt_q + 1'b1;
                if ((mism || spur) && err_q != '1) err_q <= err_q + 1'b1;
                if (mism || spur || tmo_hit) fail_q <= 1'b1;
                if (tmo_hit) tmo_flag_q <= 1'b1;
                if (mism && !mis_seen_q) begin
                    ferr_q     <= chk_cnt_q[ADDR_W-1:0];
                    mis_seen_q <= 1'b1;
                end
            end
            if (state_q != DRAIN || vld) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign wr_addr        = wr_addr_q;
    assign wr_data        = wgen_data ^ DATA_W'(inj_bit);
    assign rd_addr        = rd_addr_q;
    assign pass           = (state_q == DONE) && !fail_q;
    assign fail           = fail_q;
    assign timeout        = tmo_flag_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_mem_test_chk.sv
// Directed bench for mem_test_chk with a latency/stall memory model.
// Table of passes plus hand sequences for spurious data and reset.
module tb_mem_test_chk;

    localparam int NW = 503;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        wr_rdy = 1'b0;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_rdy = 1'b0;
    logic        rd_en;
    logic [23:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic        rd_data_valid = 1'b0;
    logic        busy, pass, fail, timeout;
    logic [15:0] err_cnt;
    logic [23:0] first_err_addr;
`ifdef MEM_TEST_CHK_INJ_EN
    logic        inj_err = 1'b0;
`endif

    mem_test_chk dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
`ifdef MEM_TEST_CHK_INJ_EN
        .inj_err        (inj_err),
`endif
        .wr_rdy         (wr_rdy),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_rdy         (rd_rdy),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .busy           (busy),
        .pass           (pass),
        .fail           (fail),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          addr;
        int          due;
    } rsp_t;

    logic [31:0] mem [NW];
    rsp_t        q[$];
    int cyc = 0, last_due = 0;
    int stall_pct = 0, lat_min = 1, lat_max = 1;
    int cor_a = -1, cor_b = -1;
    bit drop = 0, inj_spur = 0, spur_done = 0;
    int wcnt = 0, rcnt = 0, tb_out = 0, max_out = 0;
    int errors = 0, checks = 0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // memory model: inputs change on the falling edge
    always @(negedge clk) begin
        rsp_t r;
        bit   spur_now;
        int   due;
        cyc++;
        spur_now = inj_spur && !spur_done && (wcnt == NW);
        wr_rdy = ($urandom_range(99) >= stall_pct);
        rd_rdy = ($urandom_range(99) >= stall_pct)
                 && !(inj_spur && !spur_done);
        rd_data_valid = 1'b0;
        rd_data = '0;
        if (spur_now) begin
            rd_data_valid = 1'b1;
            spur_done = 1;
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            r = q.pop_front();
            if (!(drop && r.addr == NW - 1)) begin
                rd_data_valid = 1'b1;
                rd_data = r.d;
            end
        end
        #1;
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            wcnt++;
        end
        if (rd_en) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = int'(rd_addr);
            r.d = mem[rd_addr];
            if (r.addr == cor_a || r.addr == cor_b) r.d = r.d ^ 32'h1;
            r.due = due;
            q.push_back(r);
            rcnt++;
            tb_out++;
        end
        if (rd_data_valid && !spur_now && tb_out > 0) tb_out--;
        if (tb_out > max_out) max_out = tb_out;
    end

    task automatic run_pass(input logic [1:0] m);
        int n;
        bit relaunched;
        wcnt = 0;
        rcnt = 0;
        tb_out = 0;
        max_out = 0;
        @(negedge clk);
        mode = m;
        start = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("launch_busy", busy, 1);
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
            if (n == 50) start = 1'b0;
            if (n == 60) start = 1'b1;
        end
        check("pass_ends", busy, 0);
        relaunched = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) relaunched = 1;
        end
        check("held_start_no_relaunch", relaunched, 0);
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  m;
        int          stall;
        int          lmin;
        int          lmax;
        int          ca;
        int          cb;
        bit          drop;
        bit          ep;
        bit          ef;
        bit          et;
        int          ee;
        int          efa;
        int          pidx;
        logic [31:0] pval;
    } vec_t;

    vec_t tv[5];

    initial begin
        int n;
        tv[0] = '{2'd0, 0, 1, 1, -1, -1, 0, 1, 0, 0, 0, 0,
                  5, 32'hFFFF_FFFF};
        tv[1] = '{2'd2, 30, 3, 12, -1, -1, 0, 1, 0, 0, 0, 0,
                  2, 32'hC030_0002};
        tv[2] = '{2'd1, 0, 1, 1, 17, 200, 0, 0, 1, 0, 2, 17,
                  300, 32'd300};
        tv[3] = '{2'd0, 0, 1, 1, -1, -1, 1, 0, 1, 1, 0, 0,
                  0, 32'hFFFF_FFFF};
        tv[4] = '{2'd3, 0, 2, 5, -1, -1, 0, 1, 0, 0, 0, 0,
                  33, 32'h0000_0002};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err_addr, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            stall_pct = tv[i].stall;
            lat_min = tv[i].lmin;
            lat_max = tv[i].lmax;
            cor_a = tv[i].ca;
            cor_b = tv[i].cb;
            drop = tv[i].drop;
            run_pass(tv[i].m);
            check($sformatf("v%0d_pass", i), pass, tv[i].ep);
            check($sformatf("v%0d_fail", i), fail, tv[i].ef);
            check($sformatf("v%0d_timeout", i), timeout, tv[i].et);
            check($sformatf("v%0d_err_cnt", i), err_cnt, tv[i].ee);
            check($sformatf("v%0d_first_err", i), first_err_addr,
                  tv[i].efa);
            check($sformatf("v%0d_writes", i), wcnt, NW);
            check($sformatf("v%0d_reads", i), rcnt, NW);
            check($sformatf("v%0d_pattern", i), mem[tv[i].pidx],
                  tv[i].pval);
            check($sformatf("v%0d_max_out_le8", i), max_out <= 8, 1);
            drop = 0;
            q.delete();
        end
        cor_a = -1;
        cor_b = -1;

        // extra response in READ with nothing outstanding
        stall_pct = 0;
        lat_min = 1;
        lat_max = 1;
        wcnt = 0;
        spur_done = 0;
        inj_spur = 1;
        run_pass(2'd0);
        check("spur_seen", spur_done, 1);
        check("spur_fail", fail, 1);
        check("spur_pass", pass, 0);
        check("spur_err_cnt", err_cnt, 1);
        check("spur_timeout", timeout, 0);
        inj_spur = 0;

        // reset in the middle of READ, then a fresh walking-one pass
        lat_min = 3;
        lat_max = 12;
        wcnt = 0;
        rcnt = 0;
        @(negedge clk);
        mode = 2'd2;
        start = 1'b1;
        n = 0;
        while (rcnt < 100 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("mid_read_reached", rcnt >= 100, 1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_pass", pass, 0);
        check("midrst_fail", fail, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_rd_en", rd_en, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("late_rsp_drained", q.size(), 0);
        check("idle_after_late_rsp", busy, 0);
        check("idle_err_cnt", err_cnt, 0);
        run_pass(2'd3);
        check("post_rst_pass", pass, 1);
        check("post_rst_fail", fail, 0);
        check("post_rst_err_cnt", err_cnt, 0);
        check("post_rst_walk31", mem[31], 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
